addr_gen_seq: RTL

- Sequential address generator for the conv/pool datapath.
- Walks every output pixel of a feature map and, per pixel, issues KSIZE*KSIZE read addresses followed by one write address.
- Covers both the convolution stage (stride 1) and the pooling stage (stride KSIZE).
- Sits between the layer controller (start/mode/done) and the shared feature-map RAM port, which paces it with a valid/ready handshake.

---
 rtl/addr_gen_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/addr_gen_seq.sv
// Sequential read/write address generator for the conv (stride 1) and pool (stride KSIZE) stages.
// Optional macro ADDR_GEN_STALL_CNT_EN adds the stall_cnt output counting back-pressured ISSUE cycles.
module addr_gen_seq #(
    parameter int IMG_W         = 8,
    parameter int KSIZE         = 2,
    parameter int ADDR_W        = 8,
    parameter int CONV_SRC_BASE = 0,
    parameter int CONV_DST_BASE = 64,
    parameter int POOL_DST_BASE = 128
) (
`ifdef ADDR_GEN_STALL_CNT_EN
    output logic [15:0]                          stall_cnt,
`endif
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 mode,
    output logic [ADDR_W-1:0]                    addr,
    output logic                                 addr_valid,
    input  logic                                 addr_ready,
    output logic                                 addr_we,
    output logic [$clog2(KSIZE*KSIZE+1)-1:0]     tap,
    output logic [3:0]                           pix_col,
    output logic [3:0]                           pix_row,
    output logic                                 busy,
    output logic                                 done
);

    localparam int NTAPS = KSIZE * KSIZE;
    localparam int TAP_W = $clog2(NTAPS + 1);
    localparam int CW    = IMG_W - KSIZE + 1;
    localparam int PW    = CW / KSIZE;
    localparam int IW    = (ADDR_W + 4 > 32) ? ADDR_W + 4 : 32;
    localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t state, state_next;

    logic             mode_q;
    logic [TAP_W-1:0] tap_q;
    logic [KW-1:0]    kx_q, ky_q;
    logic [3:0]       col_q, row_q;
    logic [3:0]       last_idx;
    logic             write_beat;
    logic             last_pix;

    logic [IW-1:0] row_w, col_w, kx_w, ky_w;
    logic [IW-1:0] rd_conv, rd_pool, wr_conv, wr_pool, addr_full;

    assign last_idx   = mode_q ? 4'(PW - 1) : 4'(CW - 1);
    assign write_beat = (tap_q == TAP_W'(NTAPS));
    assign last_pix   = (col_q == last_idx) && (row_q == last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_valid = 1'b0;
        addr_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        addr       = '0;
        tap        = tap_q;
        pix_col    = col_q;
        pix_row    = row_q;
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                addr_we    = write_beat;
                addr       = ADDR_W'(addr_full);
                if (addr_ready && write_beat && last_pix) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pool windows are KSIZE apart in both directions; conv output keeps the input pitch.
    assign row_w   = IW'(row_q);
    assign col_w   = IW'(col_q);
    assign kx_w    = IW'(kx_q);
    assign ky_w    = IW'(ky_q);
    assign rd_conv = IW'(CONV_SRC_BASE) + (row_w + ky_w) * IW'(IMG_W) + col_w + kx_w;
    assign rd_pool = IW'(CONV_DST_BASE) + (row_w * IW'(KSIZE) + ky_w) * IW'(IMG_W)
                     + col_w * IW'(KSIZE) + kx_w;
    assign wr_conv = IW'(CONV_DST_BASE) + row_w * IW'(IMG_W) + col_w;
    assign wr_pool = IW'(POOL_DST_BASE) + row_w * IW'(PW) + col_w;

    always_comb begin
        addr_full = '0;
        if (write_beat) addr_full = mode_q ? wr_pool : wr_conv;
        else            addr_full = mode_q ? rd_pool : rd_conv;
    end

    // Counters only move on an accepted beat, so a stalled beat holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            tap_q  <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        tap_q  <= '0;
                        kx_q   <= '0;
                        ky_q   <= '0;
                        col_q  <= '0;
                        row_q  <= '0;
                    end
                end
                ISSUE: begin
                    if (addr_ready) begin
                        if (write_beat) begin
                            tap_q <= '0;
                            kx_q  <= '0;
                            ky_q  <= '0;
                            if (last_pix) begin
                                col_q <= '0;
                                row_q <= '0;
                            end else if (col_q == last_idx) begin
                                col_q <= '0;
                                row_q <= row_q + 4'd1;
                            end else begin
                                col_q <= col_q + 4'd1;
                            end
                        end else begin
                            tap_q <= tap_q + TAP_W'(1);
                            if (kx_q == KW'(KSIZE - 1)) begin
                                kx_q <= '0;
                                ky_q <= ky_q + KW'(1);
                            end else begin
                                kx_q <= kx_q + KW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDR_GEN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == ISSUE && !addr_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
